imem_fetch_ctrl: RTL and testbench

Fetch sequencer for the pipelined MIPS core when instruction memory has variable latency behind a req/ack handshake.
- Owns the architectural fetch PC.
- Issues memory requests and delivers instruction/PC+4 into the IF/ID register.
- Inserts NOP bubbles while memory is slow, honours decode stalls, and squashes in-flight fetches on a taken branch.
- Sits between the hazard unit, the IF/ID register and the instruction memory port.

---
 rtl/imem_fetch_ctrl_pkg.sv | 18 +
 rtl/fetch_skid_buf.sv | 44 ++++
 rtl/imem_fetch_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer and its IF/ID-side helpers.
// The optional watchdog is enabled with IMEM_FETCH_TIMEOUT_EN.
package imem_fetch_ctrl_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(4);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry instruction + PC+4 buffer that parks a fetched word while decode is stalled.
// Part of imem_fetch_ctrl (optional watchdog macro IMEM_FETCH_TIMEOUT_EN does not affect it).
module fetch_skid_buf
  import imem_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              unload,
  input  logic              clear,
  input  logic [WORD_W-1:0] instr_in,
  input  logic [WORD_W-1:0] pcplus4_in,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pcplus4_out,
  output logic              vld
);

  logic [WORD_W-1:0] instr_p0;
  logic [WORD_W-1:0] pcplus4_p0;
  logic              vld_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
    end else if (load) begin
      vld_p0 <= 1'b1;
    end else if (clear || unload) begin
      vld_p0 <= 1'b0;
    end
  end

  // Payload carries no reset; vld_p0 qualifies it.
  always_ff @(posedge clk) begin
    if (load) begin
      instr_p0   <= instr_in;
      pcplus4_p0 <= pcplus4_in;
    end
  end

  assign instr_out   = instr_p0;
  assign pcplus4_out = pcplus4_p0;
  assign vld         = vld_p0;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives a variable-latency req/ack instruction memory and
// fills IF/ID with words or bubbles. Define IMEM_FETCH_TIMEOUT_EN to add the fetch_err watchdog.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEF,
  parameter int WAIT_W = 8
`ifdef IMEM_FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] pc_init,
  input  logic              stallD,
  input  logic              pcsrcD,
  input  logic [WORD_W-1:0] pcbranchD,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] instrD,
  output logic [WORD_W-1:0] pcplus4D,
  output logic              fetch_bubble,
`ifdef IMEM_FETCH_TIMEOUT_EN
  output logic              fetch_err,
`endif
  output logic [WAIT_W-1:0] wait_cnt
);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  fetch_state_e      state, state_n;
  logic [WORD_W-1:0] pc_p0, pc_n;
  logic [WORD_W-1:0] addr_p0, addr_n;
  logic              req_p0, req_n;
  logic [WAIT_W-1:0] wait_p0, wait_n;
  logic [WORD_W-1:0] instr_p1, instr_n;
  logic [WORD_W-1:0] pcplus4_p1, pcplus4_n;
  logic              bubble_p1, bubble_n;
  logic              ack;
  logic [WORD_W-1:0] pc_inc;
  logic              buf_load, buf_unload, buf_clear, buf_vld;
  logic [WORD_W-1:0] buf_instr, buf_pcplus4;
`ifdef IMEM_FETCH_TIMEOUT_EN
  logic              err_p0, err_n;
`endif

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (buf_load),
    .unload     (buf_unload),
    .clear      (buf_clear),
    .instr_in   (mem_rdata),
    .pcplus4_in (pc_inc),
    .instr_out  (buf_instr),
    .pcplus4_out(buf_pcplus4),
    .vld        (buf_vld)
  );

  assign ack    = req_p0 & mem_ack;
  assign pc_inc = pc_plus4(pc_p0);

  always_comb begin
    state_n    = state;
    pc_n       = pc_p0;
    addr_n     = addr_p0;
    req_n      = req_p0;
    instr_n    = instr_p1;
    pcplus4_n  = pcplus4_p1;
    bubble_n   = bubble_p1;
    buf_load   = 1'b0;
    buf_unload = 1'b0;
    buf_clear  = 1'b0;
    wait_n     = wait_p0;
    if (ack) begin
      wait_n = '0;
    end else if (req_p0) begin
      wait_n = sat_inc(wait_p0);
    end
`ifdef IMEM_FETCH_TIMEOUT_EN
    err_n = err_p0;
    if (err_p0) begin
      req_n     = 1'b0;
      instr_n   = NOP_WORD;
      pcplus4_n = '0;
      bubble_n  = 1'b0;
    end else
`endif
    if (pcsrcD) begin
      // A still-pending fetch must complete on the bus before the target can be issued.
      pc_n      = pcbranchD;
      instr_n   = NOP_WORD;
      pcplus4_n = '0;
      bubble_n  = 1'b0;
      buf_clear = 1'b1;
      if (req_p0 && !ack) begin
        state_n = ST_SQUASH;
      end else begin
        state_n = ST_REQ;
        req_n   = 1'b1;
        addr_n  = pcbranchD;
      end
    end else begin
      case (state)
        ST_REQ: begin
          if (ack) begin
            pc_n   = pc_inc;
            addr_n = pc_inc;
            if (!stallD) begin
              instr_n   = mem_rdata;
              pcplus4_n = pc_inc;
              bubble_n  = 1'b0;
            end else begin
              buf_load = 1'b1;
              req_n    = 1'b0;
              state_n  = ST_HOLD;
            end
          end else if (!req_p0) begin
            req_n = 1'b1;
          end else if (!stallD) begin
            instr_n   = NOP_WORD;
            pcplus4_n = '0;
            bubble_n  = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stallD) begin
            instr_n    = buf_vld ? buf_instr : NOP_WORD;
            pcplus4_n  = buf_vld ? buf_pcplus4 : '0;
            bubble_n   = !buf_vld;
            buf_unload = 1'b1;
            req_n      = 1'b1;
            addr_n     = pc_p0;
            state_n    = ST_REQ;
          end
        end
        ST_SQUASH: begin
          if (ack) begin
            addr_n  = pc_p0;
            state_n = ST_REQ;
          end
        end
        default: state_n = ST_REQ;
      endcase
    end
`ifdef IMEM_FETCH_TIMEOUT_EN
    if (!err_p0 && req_p0 && !ack && wait_n == WAIT_W'(TIMEOUT_CYC)) begin
      err_n     = 1'b1;
      req_n     = 1'b0;
      state_n   = state;
      instr_n   = NOP_WORD;
      pcplus4_n = '0;
      bubble_n  = 1'b0;
    end
`endif
  end

  // Fetch stage (p0) and IF/ID register (p1)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_REQ;
      pc_p0      <= pc_init;
      addr_p0    <= pc_init;
      req_p0     <= 1'b0;
      wait_p0    <= '0;
      instr_p1   <= NOP_WORD;
      pcplus4_p1 <= '0;
      bubble_p1  <= 1'b0;
    end else begin
      state      <= state_n;
      pc_p0      <= pc_n;
      addr_p0    <= addr_n;
      req_p0     <= req_n;
      wait_p0    <= wait_n;
      instr_p1   <= instr_n;
      pcplus4_p1 <= pcplus4_n;
      bubble_p1  <= bubble_n;
    end
  end

`ifdef IMEM_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_p0 <= 1'b0;
    end else begin
      err_p0 <= err_n;
    end
  end
  assign fetch_err = err_p0;
`endif

  assign mem_req      = req_p0;
  assign mem_addr     = addr_p0;
  assign instrD       = instr_p1;
  assign pcplus4D     = pcplus4_p1;
  assign fetch_bubble = bubble_p1;
  assign wait_cnt     = wait_p0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl; the memory returns 0xC000_0000 ^ address as instruction data.
// Build with IMEM_FETCH_TIMEOUT_EN defined to exercise the watchdog instead of wait_cnt saturation.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_init, pcbranchD, mem_addr, mem_rdata, instrD, pcplus4D;
  logic        stallD, pcsrcD, mem_req, mem_ack, fetch_bubble;
  logic [7:0]  wait_cnt;
`ifdef IMEM_FETCH_TIMEOUT_EN
  logic        fetch_err;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign mem_rdata = 32'hC000_0000 ^ mem_addr;

  imem_fetch_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc_init     (pc_init),
    .stallD      (stallD),
    .pcsrcD      (pcsrcD),
    .pcbranchD   (pcbranchD),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instrD      (instrD),
    .pcplus4D    (pcplus4D),
    .fetch_bubble(fetch_bubble),
`ifdef IMEM_FETCH_TIMEOUT_EN
    .fetch_err   (fetch_err),
`endif
    .wait_cnt    (wait_cnt)
  );

  typedef struct {
    logic        stall;
    logic        src;
    logic [31:0] tgt;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        bub;
    logic [7:0]  wcnt;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic er, input logic [31:0] ea,
                            input logic [31:0] ei, input logic [31:0] ep, input logic eb,
                            input logic [7:0] ew);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(er));
    chk({tag, ".mem_addr"}, mem_addr, ea);
    chk({tag, ".instrD"}, instrD, ei);
    chk({tag, ".pcplus4D"}, pcplus4D, ep);
    chk({tag, ".fetch_bubble"}, 32'(fetch_bubble), 32'(eb));
    chk({tag, ".wait_cnt"}, 32'(wait_cnt), 32'(ew));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           stall src tgt           ack  req addr          instr         p4            bub wcnt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h0,         32'h0,   1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 32'hC000_0100, 32'h104, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 32'hC000_0104, 32'h108, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 32'hC000_0108, 32'h10C, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h0,         32'h0,   1'b1, 8'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h0,         32'h0,   1'b1, 8'd2};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 32'h0,         32'h0,   1'b1, 8'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h110, 32'hC000_010C, 32'h110, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h114, 32'hC000_010C, 32'h110, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h114, 32'hC000_010C, 32'h110, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h114, 32'hC000_0110, 32'h114, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h118, 32'hC000_0114, 32'h118, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h118, 32'hC000_0114, 32'h118, 1'b0, 8'd1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h118, 32'h0,         32'h0,   1'b1, 8'd2};
    vecs[14] = '{1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h118, 32'h0,         32'h0,   1'b0, 8'd3};
    vecs[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h118, 32'h0,         32'h0,   1'b0, 8'd4};
    vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'h0,         32'h0,   1'b0, 8'd0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 32'hC000_0200, 32'h204, 1'b0, 8'd0};
    vecs[18] = '{1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 32'h300, 32'h0,         32'h0,   1'b0, 8'd0};
    vecs[19] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h304, 32'hC000_0300, 32'h304, 1'b0, 8'd0};
    vecs[20] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h308, 32'hC000_0300, 32'h304, 1'b0, 8'd0};
    vecs[21] = '{1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 32'h400, 32'h0,         32'h0,   1'b0, 8'd0};
    vecs[22] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h404, 32'hC000_0400, 32'h404, 1'b0, 8'd0};
    vecs[23] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h404, 32'h0,         32'h0,   1'b1, 8'd1};
    vecs[24] = '{1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 32'h404, 32'h0,         32'h0,   1'b0, 8'd2};
    vecs[25] = '{1'b0, 1'b1, 32'h600, 1'b0, 1'b1, 32'h404, 32'h0,         32'h0,   1'b0, 8'd3};
    vecs[26] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h600, 32'h0,         32'h0,   1'b0, 8'd0};
    vecs[27] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h604, 32'hC000_0600, 32'h604, 1'b0, 8'd0};

    reset_n   = 1'b0;
    pc_init   = 32'h100;
    stallD    = 1'b0;
    pcsrcD    = 1'b0;
    pcbranchD = 32'h0;
    mem_ack   = 1'b0;
    step();
    step();
    check_outs("reset", 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 8'd0);
`ifdef IMEM_FETCH_TIMEOUT_EN
    chk("reset.fetch_err", 32'(fetch_err), 32'h0);
`endif

    reset_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      stallD    = vecs[i].stall;
      pcsrcD    = vecs[i].src;
      pcbranchD = vecs[i].tgt;
      mem_ack   = vecs[i].ack;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].instr,
                 vecs[i].p4, vecs[i].bub, vecs[i].wcnt);
    end
    stallD  = 1'b0;
    pcsrcD  = 1'b0;
    mem_ack = 1'b0;

`ifdef IMEM_FETCH_TIMEOUT_EN
    for (int i = 0; i < 64; i++) step();
    chk("timeout.fetch_err", 32'(fetch_err), 32'h1);
    check_outs("timeout", 1'b0, 32'h604, 32'h0, 32'h0, 1'b0, 8'd64);
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("timeout_sticky.fetch_err", 32'(fetch_err), 32'h1);
    check_outs("timeout_sticky", 1'b0, 32'h604, 32'h0, 32'h0, 1'b0, 8'd64);
`else
    for (int i = 0; i < 260; i++) step();
    check_outs("saturate", 1'b1, 32'h604, 32'h0, 32'h0, 1'b1, 8'd255);
    mem_ack = 1'b1;
    step();
    check_outs("sat_ack", 1'b1, 32'h608, 32'hC000_0604, 32'h608, 1'b0, 8'd0);
`endif

    // Asynchronous reset in the middle of a cycle, then a fetch across the address wrap.
    pc_init = 32'hFFFF_FFFC;
    #2;
    reset_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 8'd0);
`ifdef IMEM_FETCH_TIMEOUT_EN
    chk("async_reset.fetch_err", 32'(fetch_err), 32'h0);
`endif
    step();
    reset_n = 1'b1;
    mem_ack = 1'b1;
    step();
    check_outs("wrap0", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 8'd0);
    step();
    check_outs("wrap1", 1'b1, 32'h0, 32'h3FFF_FFFC, 32'h0, 1'b0, 8'd0);
    step();
    check_outs("wrap2", 1'b1, 32'h4, 32'hC000_0000, 32'h4, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
